// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M/RV64M multiply-divide unit
module muldiv_unit #(
    parameter int XLEN            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    output logic            ready,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N  = XLEN / STEPS_PER_CYCLE;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          funct3_q;
    logic                neg_a_q;
    logic                neg_b_q;
    logic                b_zero_q;
    // multiplicand for multiplies, divisor for divides
    logic [XLEN-1:0]     opnd_q;
    // multiply: {partial product high, remaining multiplier bits}
    // divide:   {partial remainder, dividend bits / quotient bits}
    logic [2*XLEN-1:0]   acc_q;
    logic [2*XLEN-1:0]   acc_d;
    logic [XLEN-1:0]     result_q;
    logic [XLEN-1:0]     result_d;
    logic                done_q;

    logic                a_sgn;
    logic                b_sgn;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [XLEN-1:0]     opnd_init;
    logic [2*XLEN-1:0]   acc_init;
    logic                accept;

    // One shift-add step: add the multiplicand when the current multiplier
    // bit is set, then shift the whole accumulator right by one.
    function automatic logic [2*XLEN-1:0] mul_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   m);
        logic [XLEN:0] sum;
        sum = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : {(XLEN+1){1'b0}});
        return {sum, acc[XLEN-1:1]};
    endfunction

    // One restoring step: shift the next dividend bit into the remainder and
    // subtract the divisor if it fits; the quotient bit enters at the bottom.
    function automatic logic [2*XLEN-1:0] div_step(input logic [2*XLEN-1:0] acc,
                                                   input logic [XLEN-1:0]   d);
        logic [XLEN:0] r_sh;
        logic [XLEN:0] diff;
        r_sh = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        diff = r_sh - {1'b0, d};
        if (r_sh >= {1'b0, d}) begin
            return {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end
        return {r_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    endfunction

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    assign busy   = (state_q == S_ITER) || (state_q == S_FIX);
    assign done   = done_q;
    assign result = result_q;

    // Operand signedness, magnitudes and initial datapath load for a new request
    always_comb begin
        a_sgn = 1'b0;
        b_sgn = 1'b0;
        case (funct3)
            3'b001:  begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b010:  begin a_sgn = 1'b1; b_sgn = 1'b0; end
            3'b100:  begin a_sgn = 1'b1; b_sgn = 1'b1; end
            3'b110:  begin a_sgn = 1'b1; b_sgn = 1'b1; end
            default: begin a_sgn = 1'b0; b_sgn = 1'b0; end
        endcase
        a_neg     = a_sgn && operand_a[XLEN-1];
        b_neg     = b_sgn && operand_b[XLEN-1];
        a_mag     = a_neg ? (~operand_a + 1'b1) : operand_a;
        b_mag     = b_neg ? (~operand_b + 1'b1) : operand_b;
        opnd_init = funct3[2] ? b_mag : a_mag;
        acc_init  = {{XLEN{1'b0}}, (funct3[2] ? a_mag : b_mag)};
    end

    // STEPS_PER_CYCLE chained iteration steps per clock
    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < STEPS_PER_CYCLE; i++) begin
            if (funct3_q[2]) begin
                acc_d = div_step(acc_d, opnd_q);
            end else begin
                acc_d = mul_step(acc_d, opnd_q);
            end
        end
    end

    // Sign correction and output selection once iteration is complete
    always_comb begin
        logic [2*XLEN-1:0] prod;
        logic [XLEN-1:0]   quo;
        logic [XLEN-1:0]   rem;
        prod = (neg_a_q ^ neg_b_q) ? (~acc_q + 1'b1) : acc_q;
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        // a zero divisor keeps the all-ones quotient regardless of signs
        if ((neg_a_q ^ neg_b_q) && !b_zero_q) begin
            quo = ~quo + 1'b1;
        end
        if (neg_a_q) begin
            rem = ~rem + 1'b1;
        end
        case (funct3_q)
            3'b000:          result_d = prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011:          result_d = prod[2*XLEN-1:XLEN];
            3'b100, 3'b101:  result_d = quo;
            default:         result_d = rem;
        endcase
    end

    // Control FSM with the datapath registers it sequences
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            b_zero_q <= 1'b0;
            opnd_q   <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_ITER: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    result_q <= result_d;
                    done_q   <= 1'b1;
                    state_q  <= S_DONE;
                end
                default: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                    if (accept) begin
                        state_q  <= S_ITER;
                        cnt_q    <= CW'(N);
                        funct3_q <= funct3;
                        neg_a_q  <= a_neg;
                        neg_b_q  <= b_neg;
                        b_zero_q <= (operand_b == '0);
                        opnd_q   <= opnd_init;
                        acc_q    <= acc_init;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard testbench for muldiv_unit
module tb_muldiv_unit;

    typedef struct {
        logic [63:0] res;
        int          cyc;
        int          id;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    int   n_issued0 = 0;
    int   n_done0 = 0;
    int   n_done1 = 0;
    int   n_done2 = 0;

    logic        s0, s1, s2;
    logic [2:0]  f0, f1, f2;
    logic [31:0] a0, b0, a1, b1;
    logic [63:0] a2, b2;
    logic        rdy0, bsy0, dn0, rdy1, bsy1, dn1, rdy2, bsy2, dn2;
    logic [31:0] r0, r1;
    logic [63:0] r2;

    muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(1)) u0 (
        .clock(clk), .reset(rst), .start(s0), .funct3(f0),
        .operand_a(a0), .operand_b(b0),
        .ready(rdy0), .busy(bsy0), .done(dn0), .result(r0)
    );
    muldiv_unit #(.XLEN(32), .STEPS_PER_CYCLE(4)) u1 (
        .clock(clk), .reset(rst), .start(s1), .funct3(f1),
        .operand_a(a1), .operand_b(b1),
        .ready(rdy1), .busy(bsy1), .done(dn1), .result(r1)
    );
    muldiv_unit #(.XLEN(64), .STEPS_PER_CYCLE(1)) u2 (
        .clock(clk), .reset(rst), .start(s2), .funct3(f2),
        .operand_a(a2), .operand_b(b2),
        .ready(rdy2), .busy(bsy2), .done(dn2), .result(r2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // monitors: pop and compare whenever a unit raises done
    always @(negedge clk) begin
        if (!rst && dn0) begin
            exp_t e;
            n_done0++;
            if (q0.size() == 0) begin
                check("u0 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q0.pop_front();
                check($sformatf("u0 result #%0d", e.id), {32'd0, r0}, e.res);
                check($sformatf("u0 done cycle #%0d", e.id), 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dn1) begin
            exp_t e;
            n_done1++;
            if (q1.size() == 0) begin
                check("u1 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q1.pop_front();
                check($sformatf("u1 result #%0d", e.id), {32'd0, r1}, e.res);
                check($sformatf("u1 done cycle #%0d", e.id), 64'(cyc), 64'(e.cyc));
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && dn2) begin
            exp_t e;
            n_done2++;
            if (q2.size() == 0) begin
                check("u2 unexpected done", 64'd1, 64'd0);
            end else begin
                e = q2.pop_front();
                check($sformatf("u2 result #%0d", e.id), r2, e.res);
                check($sformatf("u2 done cycle #%0d", e.id), 64'(cyc), 64'(e.cyc));
            end
        end
    end

    // called just after a negedge; drives start for one cycle on u0
    task automatic go0(input int id, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r);
        exp_t e;
        s0 = 1'b1; f0 = f; a0 = a; b0 = b;
        e.res = {32'd0, r}; e.cyc = cyc + 34; e.id = id;
        q0.push_back(e);
        n_issued0++;
        @(negedge clk);
        s0 = 1'b0; f0 = 3'($urandom); a0 = $urandom; b0 = $urandom;
    endtask

    task automatic wait_empty(input int which);
        int n;
        n = 0;
        while (((which == 0) ? q0.size() : (which == 1) ? q1.size() : q2.size()) != 0
               && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            check($sformatf("u%0d timeout waiting for done", which), 64'd1, 64'd0);
            q0.delete(); q1.delete(); q2.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        exp_t e;
        s0 = 0; f0 = 0; a0 = 0; b0 = 0;
        s1 = 0; f1 = 0; a1 = 0; b1 = 0;
        s2 = 0; f2 = 0; a2 = 0; b2 = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset ready", {63'd0, rdy0}, 64'd1);
        check("reset busy",  {63'd0, bsy0}, 64'd0);
        check("reset done",  {63'd0, dn0},  64'd0);
        check("reset result", {32'd0, r0}, 64'd0);

        // multiplies
        go0(1, 3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB); wait_empty(0);
        go0(2, 3'b001, 32'h80000000, 32'h80000000, 32'h40000000); wait_empty(0);
        go0(3, 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE); wait_empty(0);
        go0(4, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF); wait_empty(0);

        // reset mid-ITER discards the operation
        go0(5, 3'b101, 32'd100, 32'd7, 32'd14);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        q0.delete();
        n_issued0--;
        @(negedge clk);
        rst = 1'b0;
        check("midreset ready", {63'd0, rdy0}, 64'd1);
        check("midreset busy",  {63'd0, bsy0}, 64'd0);
        check("midreset done",  {63'd0, dn0},  64'd0);
        check("midreset result", {32'd0, r0}, 64'd0);
        repeat (40) @(negedge clk);

        // divides
        go0(6,  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD); wait_empty(0);
        go0(7,  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF); wait_empty(0);
        go0(8,  3'b101, 32'd100,      32'd7, 32'd14);       wait_empty(0);
        go0(9,  3'b111, 32'd100,      32'd7, 32'd2);        wait_empty(0);

        // specials
        go0(10, 3'b100, 32'd5,        32'd0,        32'hFFFFFFFF); wait_empty(0);
        go0(11, 3'b111, 32'h1234,     32'd0,        32'h1234);     wait_empty(0);
        go0(12, 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000); wait_empty(0);
        go0(13, 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0);        wait_empty(0);

        // start pulsed while busy is ignored
        go0(14, 3'b101, 32'd1000, 32'd10, 32'd100);
        repeat (5) @(negedge clk);
        s0 = 1'b1; f0 = 3'b000; a0 = 32'd3; b0 = 32'd3;
        @(negedge clk);
        s0 = 1'b0;
        wait_empty(0);

        // back-to-back: second start in the DONE cycle
        go0(15, 3'b000, 32'd6, 32'd7, 32'd42);
        repeat (33) @(negedge clk);
        check("b2b done before reissue", {63'd0, dn0}, 64'd1);
        go0(16, 3'b111, 32'd23, 32'd5, 32'd3);
        wait_empty(0);

        // STEPS_PER_CYCLE = 4
        s1 = 1'b1; f1 = 3'b000; a1 = 32'h10000; b1 = 32'h10000;
        e.res = 64'd0; e.cyc = cyc + 10; e.id = 1;
        q1.push_back(e);
        @(negedge clk);
        s1 = 1'b0; a1 = $urandom; b1 = $urandom;
        wait_empty(1);

        // XLEN = 64
        s2 = 1'b1; f2 = 3'b011; a2 = 64'hFFFFFFFFFFFFFFFF; b2 = 64'hFFFFFFFFFFFFFFFF;
        e.res = 64'hFFFFFFFFFFFFFFFE; e.cyc = cyc + 66; e.id = 1;
        q2.push_back(e);
        @(negedge clk);
        s2 = 1'b0; a2 = 64'd0; b2 = 64'd0;
        wait_empty(2);

        repeat (5) @(negedge clk);
        check("u0 done count", 64'(n_done0), 64'(n_issued0));
        check("u1 done count", 64'(n_done1), 64'd1);
        check("u2 done count", 64'(n_done2), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
